lcd_hd44780_receiver: RTL and testbench

Synthesizable responder end of the 4-bit HD44780 LCD write interface driven by the LCD controller. It sits on the same E/RS/RW/DB[3:0] pins and runs the power-on nibble handshake. Once in 4-bit mode it reassembles bytes and decodes commands into display-state registers. It flags timing and protocol violations, so it serves as an on-chip checker and as a bench responder.

---
 rtl/lcd_pkg.sv | 17 +
 rtl/lcd_strobe_sync.sv | 34 +++
 rtl/lcd_hd44780_receiver.sv | 184 ++++++++++++++++++
 tb/tb_lcd_hd44780_receiver.sv | 128 ++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM encoding, command masks and timing defaults for the HD44780 4-bit link.
package lcd_pkg;
    typedef enum logic [1:0] {PWR_WAIT, INIT8, HI, LO} lcd_state_e;
    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_ENTRY     = 8'h04;
    localparam logic [7:0] CMD_DISPLAY   = 8'h08;
    localparam logic [7:0] CMD_FUNCTION  = 8'h20;
    localparam logic [7:0] CMD_SET_DDRAM = 8'h80;
    localparam int unsigned T_POWERUP_DEF   = 750000;
    localparam int unsigned T_GAP_CMD_DEF   = 2000;
    localparam int unsigned T_GAP_CLEAR_DEF = 82000;
    // Clear and home need the long settle time before the next byte.
    function automatic logic is_clear_home(input logic [7:0] b);
        return (b & ~(CMD_CLEAR | CMD_HOME)) == 8'h00 && (b & (CMD_CLEAR | CMD_HOME)) != 8'h00;
    endfunction
endpackage

// File: rtl/lcd_strobe_sync.sv
// lcd_strobe_sync: 2-flop synchronizer for E/RS/RW/DB with a registered falling-edge pulse.
module lcd_strobe_sync (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       e_i,
    input  logic       rs_i,
    input  logic       rw_i,
    input  logic [3:0] db_i,
    output logic       fall_pulse_o,
    output logic [3:0] nibble_o,
    output logic       rs_o,
    output logic       rw_o
);
    logic [6:0] s1_q, s2_q;
    logic [6:0] cap_q;
    logic       fall_q;
    always_ff @(posedge Clock) begin
        if (Reset) begin
            s1_q   <= '0;
            s2_q   <= '0;
            cap_q  <= '0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= {e_i, rs_i, rw_i, db_i};
            s2_q   <= s1_q;
            cap_q  <= s2_q;
            fall_q <= s2_q[6] & ~s1_q[6];
        end
    end
    assign fall_pulse_o = fall_q;
    assign rs_o         = cap_q[5];
    assign rw_o         = cap_q[4];
    assign nibble_o     = cap_q[3:0];
endmodule

// File: rtl/lcd_hd44780_receiver.sv
// lcd_hd44780_receiver: responder for the 4-bit HD44780 write bus; runs the init handshake,
// reassembles bytes, decodes commands and flags timing/protocol violations.
module lcd_hd44780_receiver
    import lcd_pkg::*;
#(
    parameter int unsigned T_POWERUP   = T_POWERUP_DEF,
    parameter int unsigned T_GAP_CMD   = T_GAP_CMD_DEF,
    parameter int unsigned T_GAP_CLEAR = T_GAP_CLEAR_DEF
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Enabled,
    input  logic       iLCD_RegisterSelect,
    input  logic       iLCD_ReadWrite,
    input  logic [3:0] iLCD_Data,
    output logic       oByteValid,
    output logic [7:0] oByte,
    output logic       oByteIsData,
    output logic       oFourBitMode,
    output logic       oDisplayOn,
    output logic       oCursorOn,
    output logic       oBlinkOn,
    output logic       oEntryIncrement,
    output logic       oEntryShift,
    output logic [6:0] oDdramAddr,
    output logic       oTimingError,
    output logic       oProtocolError
);
    logic       fall, rs, rw;
    logic [3:0] nib;
    logic [7:0] b;
    lcd_state_e state_q, state_d;
    logic [1:0]  init_q, init_d;
    logic [3:0]  hi_nib_q, hi_nib_d;
    logic        hi_rs_q, hi_rs_d, last_clr_q, last_clr_d;
    logic [31:0] gap_q, gap_d;
    logic        valid_q, valid_d, is_data_q, is_data_d, four_q, four_d;
    logic [7:0]  byte_q, byte_d;
    logic        disp_q, disp_d, cur_q, cur_d, blink_q, blink_d, inc_q, inc_d, shift_q, shift_d;
    logic [6:0]  addr_q, addr_d;
    logic        terr_q, terr_d, perr_q, perr_d;

    lcd_strobe_sync u_sync (
        .Clock(Clock), .Reset(Reset),
        .e_i(iLCD_Enabled), .rs_i(iLCD_RegisterSelect), .rw_i(iLCD_ReadWrite), .db_i(iLCD_Data),
        .fall_pulse_o(fall), .nibble_o(nib), .rs_o(rs), .rw_o(rw)
    );

    assign b = {hi_nib_q, nib};

    always_comb begin
        state_d    = state_q;
        init_d     = init_q;
        hi_nib_d   = hi_nib_q;
        hi_rs_d    = hi_rs_q;
        last_clr_d = last_clr_q;
        gap_d      = (&gap_q) ? gap_q : gap_q + 32'd1;
        valid_d    = 1'b0;
        byte_d     = byte_q;
        is_data_d  = is_data_q;
        four_d     = four_q;
        disp_d     = disp_q;
        cur_d      = cur_q;
        blink_d    = blink_q;
        inc_d      = inc_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        terr_d     = terr_q;
        perr_d     = perr_q;
        if (state_q == PWR_WAIT && gap_q >= 32'(T_POWERUP))
            state_d = INIT8;
        if (fall && rw) begin
            perr_d = 1'b1;
        end else if (fall) begin
            case (state_q)
                PWR_WAIT: terr_d = 1'b1;
                INIT8: begin
                    if (!rs && nib == 4'h3)
                        init_d = (init_q == 2'd3) ? init_q : init_q + 2'd1;
                    else if (!rs && nib == 4'h2 && init_q == 2'd3) begin
                        four_d  = 1'b1;
                        state_d = HI;
                    end else
                        perr_d = 1'b1;
                end
                HI: begin
                    hi_nib_d = nib;
                    hi_rs_d  = rs;
                    state_d  = LO;
                    if (gap_q < (last_clr_q ? 32'(T_GAP_CLEAR) : 32'(T_GAP_CMD)))
                        terr_d = 1'b1;
                end
                default: begin
                    state_d = HI;
                    if (rs != hi_rs_q)
                        perr_d = 1'b1;
                    else begin
                        valid_d    = 1'b1;
                        byte_d     = b;
                        is_data_d  = rs;
                        gap_d      = '0;
                        last_clr_d = !rs && is_clear_home(b);
                        // Highest set bit of a command selects its meaning.
                        if (rs)
                            addr_d = inc_q ? addr_q + 7'd1 : addr_q - 7'd1;
                        else if (|(b & CMD_SET_DDRAM))
                            addr_d = b[6:0];
                        else if (!b[6]) begin
                            if (|(b & CMD_FUNCTION))
                                perr_d = perr_q | b[4];
                            else if (!b[4]) begin
                                if (|(b & CMD_DISPLAY))
                                    {disp_d, cur_d, blink_d} = b[2:0];
                                else if (|(b & CMD_ENTRY))
                                    {inc_d, shift_d} = b[1:0];
                                else if (|(b & CMD_HOME))
                                    addr_d = '0;
                                else if (|(b & CMD_CLEAR)) begin
                                    addr_d = '0;
                                    inc_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= PWR_WAIT;
            init_q     <= '0;
            hi_nib_q   <= '0;
            hi_rs_q    <= 1'b0;
            last_clr_q <= 1'b0;
            gap_q      <= '0;
            valid_q    <= 1'b0;
            byte_q     <= '0;
            is_data_q  <= 1'b0;
            four_q     <= 1'b0;
            disp_q     <= 1'b0;
            cur_q      <= 1'b0;
            blink_q    <= 1'b0;
            inc_q      <= 1'b1;
            shift_q    <= 1'b0;
            addr_q     <= '0;
            terr_q     <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            hi_nib_q   <= hi_nib_d;
            hi_rs_q    <= hi_rs_d;
            last_clr_q <= last_clr_d;
            gap_q      <= gap_d;
            valid_q    <= valid_d;
            byte_q     <= byte_d;
            is_data_q  <= is_data_d;
            four_q     <= four_d;
            disp_q     <= disp_d;
            cur_q      <= cur_d;
            blink_q    <= blink_d;
            inc_q      <= inc_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            terr_q     <= terr_d;
            perr_q     <= perr_d;
        end
    end

    assign oByteValid      = valid_q;
    assign oByte           = byte_q;
    assign oByteIsData     = is_data_q;
    assign oFourBitMode    = four_q;
    assign oDisplayOn      = disp_q;
    assign oCursorOn       = cur_q;
    assign oBlinkOn        = blink_q;
    assign oEntryIncrement = inc_q;
    assign oEntryShift     = shift_q;
    assign oDdramAddr      = addr_q;
    assign oTimingError    = terr_q;
    assign oProtocolError  = perr_q;
endmodule

// File: tb/tb_lcd_hd44780_receiver.sv
// tb_lcd_hd44780_receiver: directed bench for the HD44780 responder with shortened timing constants.
module tb_lcd_hd44780_receiver;
    logic       Clock = 1'b0, Reset = 1'b1;
    logic       e = 1'b0, rsel = 1'b0, rw = 1'b0;
    logic [3:0] db = 4'h0;
    logic       oByteValid, oByteIsData, oFourBitMode, oDisplayOn, oCursorOn, oBlinkOn;
    logic       oEntryIncrement, oEntryShift, oTimingError, oProtocolError;
    logic [7:0] oByte;
    logic [6:0] oDdramAddr;
    logic [24:0] outs;
    int n_chk = 0, n_fail = 0, n_valid = 0, v0;
    logic v2, v3;

    lcd_hd44780_receiver #(.T_POWERUP(1000), .T_GAP_CMD(50), .T_GAP_CLEAR(400)) dut (
        .Clock(Clock), .Reset(Reset),
        .iLCD_Enabled(e), .iLCD_RegisterSelect(rsel), .iLCD_ReadWrite(rw), .iLCD_Data(db),
        .oByteValid(oByteValid), .oByte(oByte), .oByteIsData(oByteIsData),
        .oFourBitMode(oFourBitMode), .oDisplayOn(oDisplayOn), .oCursorOn(oCursorOn),
        .oBlinkOn(oBlinkOn), .oEntryIncrement(oEntryIncrement), .oEntryShift(oEntryShift),
        .oDdramAddr(oDdramAddr), .oTimingError(oTimingError), .oProtocolError(oProtocolError)
    );

    always #5 Clock = ~Clock;
    always @(negedge Clock) if (oByteValid) n_valid++;
    assign outs = {oByteValid, oByte, oByteIsData, oFourBitMode, oDisplayOn, oCursorOn, oBlinkOn,
                   oEntryIncrement, oEntryShift, oDdramAddr, oTimingError, oProtocolError};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic r, input logic w, input logic [3:0] d);
        @(negedge Clock);
        rsel = r; rw = w; db = d; e = 1'b1;
        repeat (4) @(negedge Clock);
        e = 1'b0;
    endtask

    // v2/v3: oByteValid after the 2nd and 3rd rising edge following the low-nibble fall.
    task automatic send(input logic r_hi, input logic r_lo, input logic [7:0] bv, input int gap);
        strobe(r_hi, 1'b0, bv[7:4]);
        repeat (10) @(negedge Clock);
        strobe(r_lo, 1'b0, bv[3:0]);
        repeat (2) @(posedge Clock);
        #1 v2 = oByteValid;
        @(posedge Clock);
        #1 v3 = oByteValid;
        repeat (gap) @(negedge Clock);
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
    endtask

    initial begin
        repeat (5) @(negedge Clock);
        #1 chk("reset_outputs", 32'(outs), 32'h400);
        Reset = 1'b0;
        repeat (100) @(negedge Clock);
        strobe(1'b0, 1'b0, 4'h3);
        repeat (6) @(negedge Clock);
        chk("early_strobe_terr", 32'(oTimingError), 1);
        chk("early_strobe_four", 32'(oFourBitMode), 0);

        do_reset();
        repeat (1100) @(negedge Clock);
        strobe(1'b0, 1'b0, 4'h3); repeat (60) @(negedge Clock);
        strobe(1'b0, 1'b0, 4'h3); repeat (60) @(negedge Clock);
        strobe(1'b0, 1'b0, 4'h3); repeat (60) @(negedge Clock);
        strobe(1'b0, 1'b0, 4'h2); repeat (60) @(negedge Clock);
        chk("init_four", 32'(oFourBitMode), 1);
        chk("init_errs", 32'({oTimingError, oProtocolError}), 0);

        v0 = n_valid;
        send(1'b0, 1'b0, 8'h28, 60);
        chk("latency_edge2", 32'(v2), 0);
        chk("latency_edge3", 32'(v3), 1);
        send(1'b0, 1'b0, 8'h0C, 60);
        send(1'b0, 1'b0, 8'h06, 60);
        send(1'b0, 1'b0, 8'h01, 450);
        chk("cmds_dcb", 32'({oDisplayOn, oCursorOn, oBlinkOn}), 32'b100);
        chk("cmds_inc_addr", 32'({oEntryIncrement, oDdramAddr}), 32'h080);
        chk("cmds_pulses", 32'(n_valid - v0), 4);
        chk("cmds_byte", 32'({oByteIsData, oByte}), 32'h001);
        chk("cmds_errs", 32'({oTimingError, oProtocolError}), 0);

        send(1'b0, 1'b0, 8'hFF, 60);
        chk("set_addr_7f", 32'(oDdramAddr), 32'h7F);
        send(1'b1, 1'b1, 8'h41, 60);
        chk("data_wrap_addr", 32'(oDdramAddr), 32'h00);
        chk("data_byte", 32'({oByteIsData, oByte}), 32'h141);
        chk("data_terr", 32'(oTimingError), 0);

        send(1'b0, 1'b0, 8'h01, 100);
        send(1'b0, 1'b0, 8'h80, 60);
        chk("short_gap_terr", 32'(oTimingError), 1);
        chk("short_gap_accepted", 32'({v3, oByte}), 32'h180);

        v0 = n_valid;
        send(1'b0, 1'b1, 8'h41, 60);
        chk("rs_mismatch_valid", 32'(n_valid - v0), 0);
        chk("rs_mismatch_perr", 32'(oProtocolError), 1);
        send(1'b0, 1'b0, 8'h0F, 60);
        chk("after_mismatch_dcb", 32'({v3, oDisplayOn, oCursorOn, oBlinkOn}), 32'hF);
        send(1'b0, 1'b0, 8'h04, 60);
        send(1'b1, 1'b1, 8'h42, 60);
        chk("decrement_wrap", 32'({oEntryIncrement, oDdramAddr}), 32'h07F);

        strobe(1'b0, 1'b0, 4'h8);
        repeat (5) @(negedge Clock);
        do_reset();
        #1 chk("midbyte_reset", 32'(outs), 32'h400);
        repeat (100) @(negedge Clock);
        strobe(1'b0, 1'b1, 4'h3);
        repeat (6) @(negedge Clock);
        chk("rw_strobe_errs", 32'({oTimingError, oProtocolError}), 32'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
